// File: rtl/fpaddsub_norm_shift_seq.sv
// Sequential normalizer for the FP add/sub datapath.
// Shifts the raw sum significand into place one step per cycle.
module fpaddsub_norm_shift_seq #(
    parameter int EXPONENT = 5,
    parameter int MANTISSA = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MANTISSA+1:0] in_mant,
    input  logic [EXPONENT-1:0] in_exp,
    input  logic                in_sign,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MANTISSA:0]   out_mant,
    output logic [EXPONENT-1:0] out_exp,
    output logic                out_sign,
    output logic                out_zero,
    output logic                out_ovf,
    output logic                out_sticky
);

    localparam logic [EXPONENT-1:0] EMAX  = '1;
    localparam logic [EXPONENT-1:0] EONE  = EXPONENT'(1);
    localparam logic [EXPONENT-1:0] EFOUR = EXPONENT'(4);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              st;
    logic [MANTISSA+1:0] mant;
    logic [EXPONENT-1:0] exp_q;
    logic                sign_q;

    logic                fin;
    logic [MANTISSA+1:0] n_mant;
    logic [EXPONENT-1:0] n_exp;
    logic [EXPONENT-1:0] inc;
    logic [MANTISSA:0]   r_mant;
    logic [EXPONENT-1:0] r_exp;
    logic                r_zero;
    logic                r_ovf;
    logic                r_sticky;

    // One priority rule per SHIFT cycle; fin marks a terminal rule.
    always_comb begin
        fin      = 1'b1;
        n_mant   = mant;
        n_exp    = exp_q;
        inc      = exp_q + EONE;
        r_mant   = mant[MANTISSA:0];
        r_exp    = exp_q;
        r_zero   = 1'b0;
        r_ovf    = 1'b0;
        r_sticky = 1'b0;
        if (exp_q == EMAX) begin
            r_mant = '0;
            r_ovf  = 1'b1;
        end else if (mant == '0) begin
            r_mant = '0;
            r_exp  = '0;
            r_zero = 1'b1;
        end else if (mant[MANTISSA+1]) begin
            r_mant   = mant[MANTISSA+1:1];
            r_sticky = mant[0];
            r_exp    = inc;
            if (inc == EMAX) begin
                r_mant = '0;
                r_ovf  = 1'b1;
            end
        end else if (mant[MANTISSA]) begin
            r_exp = exp_q;
        end else if (exp_q == EONE) begin
            r_exp = '0;
        end else begin
            fin = 1'b0;
            if (mant[MANTISSA-:4] == 4'd0 && exp_q > EFOUR) begin
                n_mant = mant << 4;
                n_exp  = exp_q - EFOUR;
            end else begin
                n_mant = mant << 1;
                n_exp  = exp_q - EONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            mant       <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_mant   <= '0;
            out_exp    <= '0;
            out_sign   <= 1'b0;
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
            out_sticky <= 1'b0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (in_valid) begin
                        mant       <= in_mant;
                        exp_q      <= (in_exp == '0) ? EONE : in_exp;
                        sign_q     <= in_sign;
                        out_zero   <= 1'b0;
                        out_ovf    <= 1'b0;
                        out_sticky <= 1'b0;
                        in_ready   <= 1'b0;
                        st         <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fin) begin
                        out_mant   <= r_mant;
                        out_exp    <= r_exp;
                        out_sign   <= sign_q;
                        out_zero   <= r_zero;
                        out_ovf    <= r_ovf;
                        out_sticky <= r_sticky;
                        out_valid  <= 1'b1;
                        st         <= DONE;
                    end else begin
                        mant  <= n_mant;
                        exp_q <= n_exp;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        st        <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fpaddsub_norm_shift_seq.md
FPADDSUB_NORM_SHIFT_SEQ -- requirements
Module: fpaddsub_norm_shift_seq

Interface
REQ-001 The block SHALL provide parameter EXPONENT, default 5, exponent field width.
REQ-002 The block SHALL provide parameter MANTISSA, default 10, stored fraction width; significand is MANTISSA+1 bits with the hidden bit at [MANTISSA].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  input record valid.
REQ-006 in_ready  output  1  block can accept a record.
REQ-007 in_mant  input  MANTISSA+2  raw sum significand; bit [MANTISSA+1] is the adder carry.
REQ-008 in_exp  input  EXPONENT  exponent of the larger operand.
REQ-009 in_sign  input  1  result sign, passed through.
REQ-010 out_valid  output  1  result record valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_mant  output  MANTISSA+1  normalized significand.
REQ-013 out_exp  output  EXPONENT  adjusted exponent.
REQ-014 out_sign, out_zero, out_ovf, out_sticky  output  1 each  sign, zero result, overflow to infinity, bit lost by a right shift.

Function
REQ-015 The block SHALL have states IDLE, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 In IDLE with in_valid=1, the block SHALL capture mant, sign and internal exp = max(in_exp,1), clear flags, and enter SHIFT.
REQ-017 In SHIFT, the block SHALL evaluate exactly one rule per cycle, in priority order:
- a) in_exp captured as all-ones: out_mant=0, out_exp=all-ones, out_ovf=1 -> DONE.
- b) mant==0: out_zero=1, exp=0 -> DONE.
- c) carry bit set: mant>>1, out_sticky=dropped LSB, exp+1 -> DONE; if the new exp is all-ones, out_mant=0 and out_ovf=1.
- d) bit [MANTISSA] set -> DONE, exp unchanged.
- e) exp==1 -> DONE with exp field forced to 0 (subnormal).
- f) top 4 significand bits all zero and exp>4: mant<<4, exp-4, stay in SHIFT.
- g) otherwise: mant<<1, exp-1, stay in SHIFT.
REQ-018 Left shifts SHALL fill with zeros and SHALL never drive exp below 1.
REQ-019 Latency SHALL be 1 cycle from the accepting edge to out_valid, plus 1 cycle per left-shift step (rules f and g); maximum 5 cycles at defaults.
REQ-020 In DONE, outputs SHALL hold stable until out_ready=1; on that edge the state SHALL return to IDLE.
REQ-021 A new record SHALL NOT be accepted in the same cycle a result is released; in_ready rises the cycle after release.
REQ-022 out_sign SHALL equal the captured in_sign in all cases, including zero results.
REQ-023 Outputs outside DONE SHALL retain their last values; consumers qualify them with out_valid.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, out_valid=0, in_ready=1, and all data outputs and flags to 0, regardless of state.
REQ-025 Deassertion of rst_n SHALL take effect at the next rising clk edge; a reset during SHIFT or DONE SHALL discard the in-flight record.

Verification
REQ-026 Normalized input: in_mant=0x400, in_exp=15 -> out_valid 1 cycle after accept, out_mant=0x400, out_exp=15, all flags 0.
REQ-027 Carry: in_mant=0xC01, in_exp=15 -> out_mant=0x600, out_exp=16, out_sticky=1, latency 1.
REQ-028 Deep cancellation: in_mant=0x001, in_exp=20 -> steps 4,4,1,1; out_mant=0x400, out_exp=10, latency 5.
REQ-029 Subnormal and zero: in_mant=0x010, in_exp=3 -> out_mant=0x040, out_exp=0; separately in_mant=0 -> out_zero=1, out_exp=0.
REQ-030 Overflow and backpressure: in_mant=0x800, in_exp=30 -> out_ovf=1, out_exp=31, out_mant=0, held 3 cycles with out_ready=0; then rst_n pulsed low mid-SHIFT -> out_valid=0 and in_ready=1 immediately.
